// File: rtl/jt12_pkg.sv
// Shared constants, busy-state type and prescaler decode for the JT12 CPU write port.
// Latency: n/a (package only).
// Backpressure: none; the CPU bus has no stall.
package jt12_pkg;

    localparam logic [7:0] PRESC6_ADDR = 8'h2D;
    localparam logic [7:0] PRESC3_ADDR = 8'h2E;
    localparam logic [7:0] PRESC2_ADDR = 8'h2F;

    // Prescaler select encoding, ordered {n6, n3, n2}
    localparam logic [2:0] PRESC_N6 = 3'b100;
    localparam logic [2:0] PRESC_N3 = 3'b010;
    localparam logic [2:0] PRESC_N2 = 3'b001;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } busy_state_e;

    // Only the register address picks the mode; unrelated addresses keep the current one.
    function automatic logic [2:0] presc_decode(input logic [7:0] addr, input logic [2:0] cur);
        logic [2:0] sel;
        sel = cur;
        case (addr)
            PRESC6_ADDR: sel = PRESC_N6;
            PRESC3_ADDR: sel = PRESC_N3;
            PRESC2_ADDR: sel = PRESC_N2;
            default:     sel = cur;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/jt12_busy_cnt.sv
// Busy flag held for BUSY_CYCLES clk_en ticks after each start pulse.
// Latency: busy rises on the edge that samples start; falls on the edge taking the last tick.
// Backpressure: none; a start while busy reloads the count.
module jt12_busy_cnt
    import jt12_pkg::*;
#(
    parameter int BUSY_CYCLES = 32,
    parameter int BUSY_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic start,
    output logic busy
);

    localparam logic [BUSY_W-1:0] LOAD_VAL = BUSY_W'(BUSY_CYCLES);
    localparam logic [BUSY_W-1:0] ONE_VAL  = BUSY_W'(1);

    busy_state_e       state_q, state_d;
    logic [BUSY_W-1:0] cnt_q, cnt_d;

    // start has priority so a write landing on the final tick still extends busy
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = BUSY;
            cnt_d   = LOAD_VAL;
        end else if (state_q == BUSY && clk_en) begin
            if (cnt_q <= ONE_VAL) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - ONE_VAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == BUSY);

endmodule

// File: rtl/jt12_prescaler_if.sv
// CPU write port: address/data latching, reg_wr strobe, prescaler select; busy only with JT12_BUSY_EN.
// Latency: one clk from the first cycle of a write strobe to reg_wr / latched registers.
// Backpressure: none; writes while busy are accepted and reload the busy count.
module jt12_prescaler_if
    import jt12_pkg::*;
#(
    parameter int BUSY_CYCLES = 32,
    parameter int BUSY_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       set_n6,
    output logic       set_n3,
    output logic       set_n2,
    output logic [7:0] reg_addr,
    output logic       reg_part,
    output logic [7:0] reg_data,
    output logic       reg_wr
);

    logic       we;
    logic       we_q;
    logic       wr_evt;
    logic       addr_evt;
    logic       data_evt;

    logic [2:0] presc_q, presc_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic       reg_part_q, reg_part_d;
    logic [7:0] reg_data_q, reg_data_d;
    logic       reg_wr_q, reg_wr_d;

    // One event per CPU write, however long the strobe is held
    assign we       = ~cs_n & ~wr_n;
    assign wr_evt   = we & ~we_q;
    assign addr_evt = wr_evt & ~addr[0];
    assign data_evt = wr_evt & addr[0];

    always_comb begin
        reg_addr_d = reg_addr_q;
        reg_part_d = reg_part_q;
        reg_data_d = reg_data_q;
        reg_wr_d   = 1'b0;
        presc_d    = presc_q;
        if (addr_evt) begin
            reg_addr_d = din;
            reg_part_d = addr[1];
        end
        if (data_evt) begin
            reg_data_d = din;
            reg_wr_d   = 1'b1;
            if (!reg_part_q) begin
                presc_d = presc_decode(reg_addr_q, presc_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            presc_q    <= PRESC_N6;
            reg_addr_q <= '0;
            reg_part_q <= 1'b0;
            reg_data_q <= '0;
            reg_wr_q   <= 1'b0;
        end else begin
            we_q       <= we;
            presc_q    <= presc_d;
            reg_addr_q <= reg_addr_d;
            reg_part_q <= reg_part_d;
            reg_data_q <= reg_data_d;
            reg_wr_q   <= reg_wr_d;
        end
    end

    assign set_n6   = presc_q[2];
    assign set_n3   = presc_q[1];
    assign set_n2   = presc_q[0];
    assign reg_addr = reg_addr_q;
    assign reg_part = reg_part_q;
    assign reg_data = reg_data_q;
    assign reg_wr   = reg_wr_q;

`ifdef JT12_BUSY_EN
    logic busy;

    jt12_busy_cnt #(
        .BUSY_CYCLES (BUSY_CYCLES),
        .BUSY_W      (BUSY_W)
    ) u_busy_cnt (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .start  (data_evt),
        .busy   (busy)
    );

    assign dout = {busy, 7'd0};
`else
    // Without the busy counter the tick input and sizing parameters have no load
    logic unused_busy_cfg;
    assign unused_busy_cfg = clk_en & (BUSY_CYCLES < (1 << BUSY_W));

    assign dout = 8'h00;
`endif

endmodule

// File: tb/tb_jt12_prescaler_if.sv
// Directed bench for jt12_prescaler_if with a reg_wr scoreboard.
module tb_jt12_prescaler_if;

`ifdef JT12_BUSY_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic       cs_n;
    logic       wr_n;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       set_n6, set_n3, set_n2;
    logic [7:0] reg_addr;
    logic       reg_part;
    logic [7:0] reg_data;
    logic       reg_wr;

    jt12_prescaler_if #(
        .BUSY_CYCLES (32),
        .BUSY_W      (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .cs_n     (cs_n),
        .wr_n     (wr_n),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .set_n6   (set_n6),
        .set_n3   (set_n3),
        .set_n2   (set_n2),
        .reg_addr (reg_addr),
        .reg_part (reg_part),
        .reg_data (reg_data),
        .reg_wr   (reg_wr)
    );

    typedef struct packed {
        logic [7:0] a;
        logic       p;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_addr = 8'h00;
    logic       exp_part = 1'b0;
    logic [2:0] exp_mode = 3'b100;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] busy_dout(input bit b);
        return (BUSY_EN && b) ? 8'h80 : 8'h00;
    endfunction

    // Scoreboard consumer: every reg_wr pulse must match the oldest pending data write
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (reg_wr === 1'b1) begin
                pulses++;
                chk("reg_wr_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_reg_addr", 32'(reg_addr), 32'(e.a));
                    chk("sb_reg_part", 32'(reg_part), 32'(e.p));
                    chk("sb_reg_data", 32'(reg_data), 32'(e.d));
                end
            end
            chk("mode_onehot", 32'($onehot({set_n6, set_n3, set_n2})), 32'd1);
        end
    end

    task automatic cyc(input logic en);
        clk_en = en;
        @(negedge clk);
        clk_en = 1'b0;
    endtask

    task automatic tick6();
        repeat (5) cyc(1'b0);
        cyc(1'b1);
    endtask

    // Records the expected effect of one CPU write, then drives it
    task automatic wr(input logic [1:0] a, input logic [7:0] d, input int hold, input logic en0);
        if (a[0] == 1'b0) begin
            exp_addr = d;
            exp_part = a[1];
        end else begin
            sb.push_back('{a: exp_addr, p: exp_part, d: d});
            if (!exp_part) begin
                case (exp_addr)
                    8'h2D:   exp_mode = 3'b100;
                    8'h2E:   exp_mode = 3'b010;
                    8'h2F:   exp_mode = 3'b001;
                    default: exp_mode = exp_mode;
                endcase
            end
        end
        cs_n = 1'b0;
        wr_n = 1'b0;
        addr = a;
        din  = d;
        cyc(en0);
        for (int i = 1; i < hold; i++) cyc(1'b0);
        cs_n = 1'b1;
        wr_n = 1'b1;
        cyc(1'b0);
    endtask

    function automatic logic [31:0] mode();
        return 32'({set_n6, set_n3, set_n2});
    endfunction

    initial begin
        int p0;
        rst    = 1'b1;
        clk_en = 1'b0;
        cs_n   = 1'b1;
        wr_n   = 1'b1;
        addr   = 2'b00;
        din    = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc(1'b0);
        mon_en = 1'b1;

        chk("rst_mode", mode(), 32'b100);
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_reg_wr", 32'(reg_wr), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'h00);
        chk("rst_reg_part", 32'(reg_part), 32'd0);
        chk("rst_reg_data", 32'(reg_data), 32'h00);

        // Address then data write selecting /2
        wr(2'b00, 8'h2F, 1, 1'b0);
        chk("addr_latch", 32'(reg_addr), 32'h2F);
        chk("addr_part", 32'(reg_part), 32'd0);
        chk("addr_no_busy", 32'(dout), 32'h00);
        wr(2'b01, 8'hFF, 1, 1'b0);
        chk("mode_2f", mode(), 32'(exp_mode));
        chk("busy_after_data", 32'(dout), 32'(busy_dout(1)));

        // Busy lasts exactly 32 clk_en ticks
        for (int k = 1; k <= 32; k++) begin
            tick6();
            chk("busy_run", 32'(dout), 32'(busy_dout(k < 32)));
        end

        // Long strobe gives a single event
        wr(2'b00, 8'h2D, 1, 1'b0);
        p0 = pulses;
        wr(2'b01, 8'h2E, 10, 1'b0);
        cyc(1'b0);
        chk("hold10_pulses", 32'(pulses - p0), 32'd1);
        chk("mode_2d_data_ignored", mode(), 32'(exp_mode));

        // Second write after 20 ticks extends busy by a full 32
        for (int k = 1; k <= 20; k++) begin
            tick6();
            chk("busy_pre_ext", 32'(dout), 32'(busy_dout(1)));
        end
        wr(2'b01, 8'h11, 1, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            tick6();
            chk("busy_ext", 32'(dout), 32'(busy_dout(k < 32)));
        end

        // Write landing on the final tick keeps busy and reloads
        wr(2'b01, 8'h22, 1, 1'b0);
        for (int k = 1; k <= 31; k++) tick6();
        chk("busy_before_last", 32'(dout), 32'(busy_dout(1)));
        repeat (5) cyc(1'b0);
        wr(2'b01, 8'h33, 1, 1'b1);
        chk("busy_coincide", 32'(dout), 32'(busy_dout(1)));
        for (int k = 1; k <= 32; k++) begin
            tick6();
            chk("busy_after_coincide", 32'(dout), 32'(busy_dout(k < 32)));
        end

        // Part 1 write to a prescaler address leaves the mode alone
        wr(2'b10, 8'h2E, 1, 1'b0);
        chk("part1_addr", 32'(reg_addr), 32'h2E);
        chk("part1_part", 32'(reg_part), 32'd1);
        p0 = pulses;
        wr(2'b11, 8'h77, 1, 1'b0);
        chk("part1_pulse", 32'(pulses - p0), 32'd1);
        chk("part1_mode", mode(), 32'b100);

        // Unrelated address leaves the mode alone
        wr(2'b00, 8'h10, 1, 1'b0);
        wr(2'b01, 8'h2F, 1, 1'b0);
        chk("other_addr_mode", mode(), 32'b100);

        // Reset while busy in /3 mode
        wr(2'b00, 8'h2E, 1, 1'b0);
        wr(2'b01, 8'h00, 1, 1'b0);
        chk("mode_2e", mode(), 32'b010);
        chk("busy_2e", 32'(dout), 32'(busy_dout(1)));
        repeat (3) tick6();
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        exp_addr = 8'h00;
        exp_part = 1'b0;
        exp_mode = 3'b100;
        chk("rst_busy_dout", 32'(dout), 32'h00);
        chk("rst_busy_mode", mode(), 32'b100);
        chk("rst_busy_addr", 32'(reg_addr), 32'h00);

        // Strobe held across reset counts again once reset drops
        p0 = pulses;
        sb.push_back('{a: exp_addr, p: exp_part, d: 8'hA5});
        cs_n = 1'b0;
        wr_n = 1'b0;
        addr = 2'b01;
        din  = 8'hA5;
        repeat (3) cyc(1'b0);
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        sb.push_back('{a: 8'h00, p: 1'b0, d: 8'hA5});
        repeat (3) cyc(1'b0);
        cs_n = 1'b1;
        wr_n = 1'b1;
        cyc(1'b0);
        chk("held_rst_pulses", 32'(pulses - p0), 32'd2);
        chk("held_rst_busy", 32'(dout), 32'(busy_dout(1)));
        chk("held_rst_mode", mode(), 32'b100);

        repeat (3) cyc(1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt12_prescaler_if.md
JT12_PRESCALER_IF -- requirements
Module: jt12_prescaler_if

Interface
REQ-001 Parameter BUSY_CYCLES, default 32: number of clk_en ticks that busy stays asserted after a data write.
REQ-002 Parameter BUSY_W, default 6: busy counter width; SHALL hold BUSY_CYCLES.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 clk_en  input  1  one-cycle internal-clock tick; it paces the busy counter.
REQ-006 cs_n  input  1  chip select, active-low.
REQ-007 wr_n  input  1  write strobe, active-low.
REQ-008 addr  input  2  addr[0]: 0 = address port, 1 = data port; addr[1]: register part (0/1).
REQ-009 din  input  8  CPU write data.
REQ-010 dout  output  8  status: {busy, 7'd0}.
REQ-011 set_n6  output  1  level, high when the /6 prescaler is selected.
REQ-012 set_n3  output  1  level, high when the /3 prescaler is selected.
REQ-013 set_n2  output  1  level, high when the /2 prescaler is selected.
REQ-014 reg_addr  output  8  latched register address.
REQ-015 reg_part  output  1  latched part bit.
REQ-016 reg_data  output  8  last data byte written.
REQ-017 reg_wr  output  1  one-cycle strobe: reg_addr/reg_part/reg_data are valid for the downstream register map.

Function
REQ-018 Write event: we = ~cs_n & ~wr_n, registered once; an event is the first cycle where we is 1 after a cycle where it was 0, so one event per CPU write regardless of strobe length.
REQ-019 Address event (addr[0]=0): reg_addr <= din and reg_part <= addr[1] on the next clk; no reg_wr; busy unaffected.
REQ-020 Data event (addr[0]=1): reg_data <= din and reg_wr = 1 for exactly one cycle, one clk after the event; reg_addr and reg_part are unchanged.
REQ-021 Prescaler decode on a data event with reg_part=0, registered on the same edge as reg_wr:
- reg_addr 8'h2D -> {n6,n3,n2} = 100
- reg_addr 8'h2E -> 010
- reg_addr 8'h2F -> 001
- any other address leaves them unchanged.
REQ-022 The data byte is ignored for the prescaler decode; only the address selects the mode.
REQ-023 Exactly one of set_n6/set_n3/set_n2 SHALL be high at all times.
REQ-024 A part=1 write to 8'h2D..2F SHALL NOT change the prescaler and SHALL still produce reg_wr.
REQ-025 Busy FSM states: IDLE and BUSY.
- A data event enters BUSY and loads the counter with BUSY_CYCLES.
- In BUSY, each clk_en decrements the counter; at 0 the FSM returns to IDLE.
REQ-026 A data event while BUSY reloads the counter and stays BUSY; the write is accepted, not dropped.
REQ-027 A data event coinciding with the final decrement wins: the counter reloads and the FSM stays BUSY.
REQ-028 dout[7] = 1 exactly while in BUSY; dout[6:0] = 0.
REQ-029 dout is valid regardless of cs_n; reads have no side effects.

Reset
REQ-030 On clk with rst=1:
- set_n6=1, set_n3=0, set_n2=0
- reg_addr=0, reg_part=0, reg_data=0, reg_wr=0
- busy FSM to IDLE, counter=0
- write-edge register cleared to 0.
REQ-031 Reset mid-busy or during a held write SHALL abort it; a strobe still held low when rst falls SHALL count as a new event.

Configuration
REQ-032 Macro JT12_BUSY_EN defined: busy FSM and counter present per REQ-025..028.
REQ-033 JT12_BUSY_EN undefined: no counter is built, dout is constant 8'h00, and all other behaviour is unchanged.

Structure
REQ-034 Package jt12_pkg SHALL hold: register constants PRESC6_ADDR=8'h2D, PRESC3_ADDR=8'h2E, PRESC2_ADDR=8'h2F; busy-state typedef {IDLE,BUSY}.
REQ-035 The busy FSM and counter SHALL be the sub-module jt12_busy_cnt (ports clk, rst, clk_en, start, busy), instantiated only under JT12_BUSY_EN.

Verification
REQ-036 Reset: after rst, {set_n6,set_n3,set_n2}=100, dout=8'h00, reg_wr=0.
REQ-037 Address write 8'h2F (addr=00), then data write 8'hFF (addr=01) -> one reg_wr pulse with reg_addr=2F, reg_data=FF; mode becomes 001; dout=8'h80.
REQ-038 Hold wr_n low for 10 cycles on a data write -> exactly one reg_wr pulse.
REQ-039 BUSY_CYCLES=32 with clk_en every 6th clk -> dout[7] falls exactly after the 32nd clk_en following the write; a second data write after 20 clk_en ticks extends busy by 32 ticks from that point.
REQ-040 Part-1 address 8'h2E (addr=10) then data -> mode unchanged, reg_part=1, reg_wr pulses.
REQ-041 rst asserted while BUSY with mode 010 -> next cycle dout=00 and mode 100; with JT12_BUSY_EN undefined, dout stays 00 throughout REQ-037/039.
